icache: RTL and testbench



---
 rtl/cpu_types_pkg.sv | 31 +++
 rtl/icache.sv | 105 ++++++++++
 tb/tb_icache.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types used by the instruction cache.
//   word_t          32-bit machine word
//   icachef_t       fetch address overlay {tag, idx, bytoff} for the default geometry
//   icache_frame_t  one cache frame {valid, tag, data}
//   icache_state_t  instruction cache controller states
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int ICACHE_SETS  = 16;
  localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
  localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

  typedef struct packed {
    logic [ICACHE_TAG_W-1:0] tag;
    logic [ICACHE_IDX_W-1:0] idx;
    logic [1:0]              bytoff;
  } icachef_t;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } icache_frame_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache.
// Hits answer in the same cycle; a miss fetches one word from the memory
// controller and fills the indexed frame, after which the fetch hits.
// Ports:
//   CLK       in   system clock, rising edge
//   nRST      in   asynchronous active-low reset
//   imemREN   in   fetch request from datapath
//   imemaddr  in   fetch byte address ([1:0] ignored)
//   ihit      out  imemload valid this cycle
//   imemload  out  instruction word (0 when not hitting)
//   iREN      out  read request to memory controller
//   iaddr     out  word-aligned read address (held miss address)
//   iwait     in   memory busy; low while iREN high means iload valid
//   iload     in   memory read data
module icache
  import cpu_types_pkg::*;
#(
  parameter int SETS = ICACHE_SETS
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  icache_state_t state_q, state_d;
  word_t         miss_addr_q, miss_addr_d;
  logic [SETS-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  word_t            data_q [SETS];

  logic [IDX_W-1:0] req_idx, miss_idx;
  logic [TAG_W-1:0] req_tag, miss_tag;
  logic             hit;
  logic             fill;
  logic             unused_bytoff;

  assign req_idx       = imemaddr[IDX_W+1:2];
  assign req_tag       = imemaddr[31:IDX_W+2];
  assign miss_idx      = miss_addr_q[IDX_W+1:2];
  assign miss_tag      = miss_addr_q[31:IDX_W+2];
  assign unused_bytoff = ^imemaddr[1:0];

  // Hits are only reported from IDLE, so the fill cycle never shows ihit.
  assign hit      = (state_q == IDLE) && imemREN && valid_q[req_idx] &&
                    (tag_q[req_idx] == req_tag);
  assign ihit     = hit;
  assign imemload = hit ? data_q[req_idx] : '0;
  // The held miss address is presented in every state so it is stable when sampled.
  assign iaddr    = miss_addr_q;

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    iREN        = 1'b0;
    fill        = 1'b0;
    case (state_q)
      IDLE: begin
        if (imemREN && !hit) begin
          miss_addr_d = {imemaddr[31:2], 2'b00};
          state_d     = FETCH;
        end
      end
      FETCH: begin
        // Runs to completion regardless of imemREN/imemaddr; fill uses miss_addr.
        iREN = 1'b1;
        if (!iwait) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      if (fill) valid_q[miss_idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid bits alone qualify them.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_q[miss_idx]  <= miss_tag;
      data_q[miss_idx] <= iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb_icache: randomized scoreboard bench for icache with a behavioural
// direct-mapped cache model and a backing memory model.
module tb_icache;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  nRST = 1'b0;
  logic  imemREN = 1'b0;
  word_t imemaddr = '0;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait = 1'b1;
  word_t iload = '0;

  always #5 CLK = ~CLK;

  icache #(.SETS(16)) dut (
    .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload)
  );

  typedef struct {
    word_t data;
    int    cyc;
    word_t addr;
  } exp_t;

  int    checks = 0;
  int    passes = 0;
  int    cyc = 0;
  exp_t  sb_q[$];
  word_t fetch_q[$];
  int    wait_q[$];
  word_t memv[word_t];

  // Reference model: one entry per set.
  bit          mvalid[16];
  logic [25:0] mtag[16];
  word_t       mdata[16];

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic word_t mem_rd(input word_t a);
    if (memv.exists(a)) return memv[a];
    return (a * 32'h9E3779B1) ^ 32'h3C010001;
  endfunction

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Decide hit/miss from the model; on a miss record the expected memory
  // read and update the model as the cache should after its fill.
  task automatic plan(input word_t a, input int n, output int lat);
    int idx;
    idx = int'(a[5:2]);
    if (mvalid[idx] && mtag[idx] == a[31:6]) begin
      lat = 0;
    end else begin
      lat = n + 2;
      fetch_q.push_back({a[31:2], 2'b00});
      wait_q.push_back(n);
      mvalid[idx] = 1'b1;
      mtag[idx]   = a[31:6];
      mdata[idx]  = mem_rd({a[31:2], 2'b00});
    end
  endtask

  task automatic wait_sb();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge CLK);
    check("ihit_timeout", word_t'(sb_q.size()), 32'd0);
    sb_q.delete();
    #1;
  endtask

  task automatic wait_fill();
    for (int i = 0; i < 100 && fetch_q.size() != 0; i++) @(posedge CLK);
    check("fill_timeout", word_t'(fetch_q.size()), 32'd0);
    fetch_q.delete();
    #1;
  endtask

  // Called at posedge+1; the current cycle is the request cycle.
  task automatic fetch(input word_t a, input int n);
    int lat;
    int start;
    start    = cyc;
    imemREN  = 1'b1;
    imemaddr = a;
    plan(a, n, lat);
    sb_q.push_back('{data: mdata[a[5:2]], cyc: start + lat, addr: a});
    wait_sb();
  endtask

  // Miss on a, then switch to b one cycle into the fetch.
  task automatic fetch_switch(input word_t a, input int na, input word_t b, input int nb);
    int lata, latb, start;
    start    = cyc;
    imemREN  = 1'b1;
    imemaddr = a;
    plan(a, na, lata);
    @(posedge CLK); #1;
    imemaddr = b;
    plan(b, nb, latb);
    sb_q.push_back('{data: mdata[b[5:2]], cyc: start + lata + latb, addr: b});
    wait_sb();
  endtask

  task automatic idle(input int k);
    imemREN  = 1'b0;
    imemaddr = $urandom;
    repeat (k) @(posedge CLK);
    #1;
  endtask

  function automatic word_t pool_addr();
    logic [25:0] tg;
    case ($urandom_range(0, 3))
      0: tg = 26'd0;
      1: tg = 26'd1;
      2: tg = 26'd2;
      default: tg = 26'h3FFFFFF;
    endcase
    return {tg, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
  endfunction

  // Memory controller model: waits the planned number of cycles per request.
  bit prev_ren = 1'b0;
  int wl = 0;
  always @(posedge CLK) begin
    #1;
    if (iREN) begin
      if (!prev_ren) wl = (wait_q.size() != 0) ? wait_q.pop_front() : 0;
      if (wl > 0) begin
        iwait = 1'b1;
        wl--;
      end else begin
        iwait = 1'b0;
        iload = mem_rd(iaddr);
      end
    end else begin
      iwait = 1'b1;
      iload = $urandom;
    end
    prev_ren = iREN;
  end

  // Monitor: compares every DUT response against the scoreboard.
  always @(negedge CLK) begin
    if (nRST) begin
      if (ihit) begin
        if (sb_q.size() == 0) begin
          check("unexpected_ihit", {31'd0, ihit}, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("imemload", imemload, e.data);
          check("hit_cycle", word_t'(cyc), word_t'(e.cyc));
          check("ihit_with_iREN", {31'd0, iREN}, 32'd0);
        end
      end
      if (iREN) begin
        if (fetch_q.size() == 0) begin
          check("spurious_iREN", {31'd0, iREN}, 32'd0);
        end else begin
          check("iaddr", iaddr, fetch_q[0]);
          if (!iwait) void'(fetch_q.pop_front());
        end
      end
    end
  end

  initial begin
    int lat;
    imemREN  = 1'b1;
    imemaddr = 32'h0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ihit", {31'd0, ihit}, 32'd0);
    check("rst_iREN", {31'd0, iREN}, 32'd0);
    check("rst_iaddr", iaddr, 32'd0);
    check("rst_imemload", imemload, 32'd0);
    nRST = 1'b1;

    // Cold miss, hit, conflict eviction.
    fetch(32'h0000_0000, 3);
    fetch(32'h0000_0000, 0);
    fetch(32'h0000_0040, 2);
    fetch(32'h0000_0000, 1);
    fetch(32'h0000_0040, 0);

    // Address changes during a miss.
    fetch_switch(32'h0000_0004, 2, 32'h0000_0008, 1);
    fetch(32'h0000_0004, 0);

    // Request withdrawn during a miss: fill still completes.
    imemREN  = 1'b1;
    imemaddr = 32'h0000_000C;
    plan(32'h0000_000C, 3, lat);
    @(posedge CLK); #1;
    imemREN = 1'b0;
    wait_fill();
    check("iREN_after_drop", {31'd0, iREN}, 32'd0);
    idle(2);
    fetch(32'h0000_000C, 0);

    // Reset during a miss.
    imemREN  = 1'b1;
    imemaddr = 32'h0000_0010;
    plan(32'h0000_0010, 5, lat);
    repeat (2) @(posedge CLK);
    #1;
    check("pre_rst_iREN", {31'd0, iREN}, 32'd1);
    nRST = 1'b0;
    #1;
    check("async_rst_iREN", {31'd0, iREN}, 32'd0);
    check("async_rst_ihit", {31'd0, ihit}, 32'd0);
    fetch_q.delete();
    wait_q.delete();
    sb_q.delete();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    imemREN = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    fetch(32'h0000_0000, 1);
    fetch(32'h0000_000C, 0);

    // Randomized traffic with occasional memory rewrites (stale lines expected).
    for (int t = 0; t < 300; t++) begin
      int r;
      word_t a;
      r = $urandom_range(0, 19);
      a = pool_addr();
      if (r == 0) begin
        memv[{a[31:2], 2'b00}] = $urandom;
      end else if (r < 3) begin
        idle($urandom_range(1, 3));
      end else if (r < 5 && !(mvalid[a[5:2]] && mtag[a[5:2]] == a[31:6])) begin
        fetch_switch(a, $urandom_range(0, 3), pool_addr(), $urandom_range(0, 3));
      end else begin
        fetch(a, $urandom_range(0, 4));
      end
    end
    idle(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
